// File: rtl/prince_sbox_layer_ctrl.sv
// Time-shares one masked PRINCE S-box over a 2-share state, one nibble per cycle.
// Optional build macro SBOX_IDLE_ZERO_EN: quiet S-box inputs and scrub captured shares when idle.
module prince_sbox_layer_ctrl #(
  parameter int NIBBLES  = 16,
  parameter int SBOX_LAT = 1,
  localparam int DATA_W  = 4 * NIBBLES
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_share0,
  input  logic [DATA_W-1:0] in_share1,
  input  logic              abort,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_share0,
  output logic [DATA_W-1:0] out_share1,
  output logic              busy,
  output logic [1:0]        sb_ina,
  output logic [1:0]        sb_inb,
  output logic [1:0]        sb_inc,
  output logic [1:0]        sb_ind,
  input  logic [3:0]        sb_out0,
  input  logic [3:0]        sb_out1
);

  localparam int CNT_W  = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam int DCNT_W = $clog2(SBOX_LAT + 1);

  typedef enum logic [1:0] {IDLE, FEED, DRAIN, DONE} state_t;

  state_t                          state, state_nxt;
  logic [CNT_W-1:0]                cnt;
  logic [DCNT_W-1:0]               dcnt;
  logic [DATA_W-1:0]               s0_q, s1_q;
  logic [DATA_W-1:0]               o0_q, o1_q;
  logic [SBOX_LAT-1:0]             vld_p;
  logic [SBOX_LAT-1:0][CNT_W-1:0]  idx_p;
  logic [3:0]                      n0, n1;
  logic                            kill;

  function automatic logic [3:0] nib(input logic [DATA_W-1:0] v, input logic [CNT_W-1:0] c);
    return v[{c, 2'b00} +: 4];
  endfunction

  assign kill       = abort && (state != IDLE);
  assign in_ready   = (state == IDLE);
  assign out_valid  = (state == DONE);
  assign busy       = (state == FEED) || (state == DRAIN);
  assign out_share0 = o0_q;
  assign out_share1 = o1_q;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (in_valid) state_nxt = FEED;
      FEED:  if (abort) state_nxt = IDLE;
             else if (cnt == CNT_W'(NIBBLES - 1)) state_nxt = DRAIN;
      DRAIN: if (abort) state_nxt = IDLE;
             else if (dcnt == DCNT_W'(SBOX_LAT - 1)) state_nxt = DONE;
      DONE:  if (abort || out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // cnt parks on the last fed nibble, so the S-box inputs hold it outside FEED
  always_comb begin
    n0 = nib(s0_q, cnt);
    n1 = nib(s1_q, cnt);
`ifdef SBOX_IDLE_ZERO_EN
    if (state != FEED) begin
      n0 = '0;
      n1 = '0;
    end
`endif
    sb_ina = {n1[0], n0[0]};
    sb_inb = {n1[1], n0[1]};
    sb_inc = {n1[2], n0[2]};
    sb_ind = {n1[3], n0[3]};
  end

  // Control: state, counters and the tagged valid pipeline
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      dcnt  <= '0;
      vld_p <= '0;
      idx_p <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE:  if (in_valid) cnt <= '0;
        FEED: begin
          if (cnt != CNT_W'(NIBBLES - 1)) cnt <= cnt + 1'b1;
          dcnt <= '0;
        end
        DRAIN: dcnt <= dcnt + 1'b1;
        default: ;
      endcase
      if (kill) begin
        vld_p <= '0;
      end else begin
        vld_p[0] <= (state == FEED);
        idx_p[0] <= cnt;
        for (int k = 1; k < SBOX_LAT; k++) begin
          vld_p[k] <= vld_p[k-1];
          idx_p[k] <= idx_p[k-1];
        end
      end
    end
  end

  // Data: captured input shares and the collected S-box results
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s0_q <= '0;
      s1_q <= '0;
      o0_q <= '0;
      o1_q <= '0;
    end else begin
      if (in_valid && state == IDLE) begin
        s0_q <= in_share0;
        s1_q <= in_share1;
      end
`ifdef SBOX_IDLE_ZERO_EN
      else if (kill || (state == DONE && out_ready)) begin
        s0_q <= '0;
        s1_q <= '0;
      end
`endif
      if (vld_p[SBOX_LAT-1] && !kill) begin
        o0_q[{idx_p[SBOX_LAT-1], 2'b00} +: 4] <= sb_out0;
        o1_q[{idx_p[SBOX_LAT-1], 2'b00} +: 4] <= sb_out1;
      end
    end
  end

endmodule
